// File: rtl/sqrt_seq_ctrl.sv
// Stage-control sequencer for the FP16 square-root pipeline: handshake, classify, iterate, round.
// Define SQRT_CTRL_FASTPATH_EN to send NaN/Inf operands straight from WAIT to DONE.
module sqrt_seq_ctrl #(
   parameter int unsigned ITERS = 12,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             flush,
   output logic [15:0]      op_out,
   output logic             stage_en,
   output logic             s_valid,
   input  logic             n_valid,
   input  logic             is_num,
   output logic             iter_start,
   output logic             iter_step,
   output logic [CNT_W-1:0] iter_cnt,
   output logic             round_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_special,
   output logic             busy
);

   typedef enum logic [2:0] {StIdle, StClass, StWait, StIter, StRound, StDone} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ITERS - 1);

   state_e           state_q, state_d;
   logic [15:0]      op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             special_q, special_d;
   logic             s_valid_q, s_valid_d;
   logic             start_q, start_d;
   logic             step_q, step_d;
   logic             round_q, round_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   // Gated by rst_n so no operand is offered a slot while reset is held.
   assign in_ready = rst_n && (state_q == StIdle) && !flush;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = '0;
      special_d = special_q;
      s_valid_d = 1'b0;
      start_d   = 1'b0;
      step_d    = 1'b0;
      round_d   = 1'b0;
      if (flush) begin
         state_d   = StIdle;
         special_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid && in_ready) begin
                  op_d      = in_data;
                  s_valid_d = 1'b1;
                  state_d   = StClass;
               end
            end
            StClass: state_d = StWait;
            StWait: begin
               if (n_valid) begin
                  special_d = !is_num;
`ifdef SQRT_CTRL_FASTPATH_EN
                  if (!is_num) begin
                     state_d = StDone;
                  end else begin
                     state_d = StIter;
                     start_d = 1'b1;
                     step_d  = 1'b1;
                  end
`else
                  state_d = StIter;
                  start_d = 1'b1;
                  step_d  = 1'b1;
`endif
               end
            end
            StIter: begin
               if (cnt_q == LastCnt) begin
                  state_d = StRound;
                  round_d = 1'b1;
               end else begin
                  cnt_d  = cnt_q + CNT_W'(1);
                  step_d = 1'b1;
               end
            end
            StRound: state_d = StDone;
            StDone: begin
               if (out_ready) begin
                  state_d   = StIdle;
                  special_d = 1'b0;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      busy_d      = (state_d != StIdle);
      out_valid_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_q        <= '0;
         cnt_q       <= '0;
         special_q   <= 1'b0;
         s_valid_q   <= 1'b0;
         start_q     <= 1'b0;
         step_q      <= 1'b0;
         round_q     <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         special_q   <= special_d;
         s_valid_q   <= s_valid_d;
         start_q     <= start_d;
         step_q      <= step_d;
         round_q     <= round_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign op_out      = op_q;
   assign iter_cnt    = cnt_q;
   assign out_special = special_q;
   assign s_valid     = s_valid_q;
   assign iter_start  = start_q;
   assign iter_step   = step_q;
   assign round_en    = round_q;
   assign out_valid   = out_valid_q;
   assign busy        = busy_q;
   assign stage_en    = busy_q;

endmodule
